add_arbiter2: RTL

ADD_ARBITER2 -- requirements
Module: add_arbiter2

---
 rtl/add_arbiter2_if.sv | 41 ++++
 rtl/add_arbiter2.sv | 93 +++++++++
 2 files changed

// File: rtl/add_arbiter2_if.sv
// Two-requester shared-adder bus: request, adder and response signals.
// slave = arbiter view, master = environment view.
interface add_arbiter2_if;
   logic       req0_valid;
   logic       req1_valid;
   logic [7:0] req0_a;
   logic [7:0] req0_b;
   logic [7:0] req1_a;
   logic [7:0] req1_b;
   logic       req0_cin;
   logic       req1_cin;
   logic       req0_ready;
   logic       req1_ready;
   logic [7:0] add_a;
   logic [7:0] add_b;
   logic       add_cin;
   logic [7:0] add_s;
   logic       add_cout;
   logic       add_o;
   logic       rsp_valid;
   logic       rsp_id;
   logic [7:0] rsp_s;
   logic       rsp_cout;
   logic       rsp_o;
   logic       rsp_ready;
   logic [7:0] ovf_count;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      input  req0_cin, req1_cin, add_s, add_cout, add_o, rsp_ready,
      output req0_ready, req1_ready, add_a, add_b, add_cin,
      output rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_o, ovf_count
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      output req0_cin, req1_cin, add_s, add_cout, add_o, rsp_ready,
      input  req0_ready, req1_ready, add_a, add_b, add_cin,
      input  rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_o, ovf_count
   );
endinterface

// File: rtl/add_arbiter2.sv
// Two-way arbiter sharing one external 8-bit adder.
// Round-robin (FAIR=1) or fixed priority (FAIR=0); one op in flight.
module add_arbiter2 #(
   parameter bit FAIR = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   add_arbiter2_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   state_t     state;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       op_cin;
   logic       last_grant;
   logic       id_q;
   logic       rsp_valid_q;
   logic [7:0] rsp_s_q;
   logic       rsp_cout_q;
   logic       rsp_o_q;
   logic [7:0] ovf_q;
   logic       win;
   logic       any_req;

   always_comb begin
      any_req = bus.req0_valid | bus.req1_valid;
      win     = bus.req1_valid & ~bus.req0_valid;
      if (FAIR) begin
         if (bus.req0_valid && bus.req1_valid)
            win = ~last_grant;
      end
   end

   // Ready is gated by rst_n so nothing is accepted while held in reset.
   assign bus.req0_ready = rst_n && (state == IDLE) && bus.req0_valid && !win;
   assign bus.req1_ready = rst_n && (state == IDLE) && bus.req1_valid && win;

   assign bus.add_a     = op_a;
   assign bus.add_b     = op_b;
   assign bus.add_cin   = op_cin;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_s     = rsp_s_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.rsp_o     = rsp_o_q;
   assign bus.ovf_count = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_a        <= '0;
         op_b        <= '0;
         op_cin      <= 1'b0;
         last_grant  <= 1'b1;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_s_q     <= '0;
         rsp_cout_q  <= 1'b0;
         rsp_o_q     <= 1'b0;
         ovf_q       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  op_a       <= win ? bus.req1_a : bus.req0_a;
                  op_b       <= win ? bus.req1_b : bus.req0_b;
                  op_cin     <= win ? bus.req1_cin : bus.req0_cin;
                  id_q       <= win;
                  last_grant <= win;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_s_q     <= bus.add_s;
               rsp_cout_q  <= bus.add_cout;
               rsp_o_q     <= bus.add_o;
               rsp_valid_q <= 1'b1;
               if (bus.add_o && ovf_q != 8'hFF)
                  ovf_q <= ovf_q + 8'd1;
               state <= HOLD;
            end
            HOLD: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
